// File: rtl/flash_adc_seq_ctrl_pkg.sv
// flash_adc_seq_ctrl_pkg: shared FSM state type and datapath widths for the flash ADC sequencer.
package flash_adc_seq_ctrl_pkg;
   localparam int CODE_W  = 3;
   localparam int THERM_W = 8;
   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_ACC, ST_HOLD} state_t;
endpackage

// File: rtl/flash_adc_seq_ctrl_encoder.sv
// adc_therm_encoder: thermometer word -> index of highest set bit (0x00 -> 0), plus raw bubble detect.
// FLASH_ADC_BUBBLE_FIX_EN enables 3-tap majority correction before encoding.
module adc_therm_encoder
   import flash_adc_seq_ctrl_pkg::*;
(
   input  logic [THERM_W-1:0] i_raw,
   output logic [CODE_W-1:0]  o_code,
   output logic               o_bubble
);
   logic [THERM_W-1:0] w_fix;
`ifdef FLASH_ADC_BUBBLE_FIX_EN
   logic [THERM_W+1:0] w_ext;
   assign w_ext = {1'b0, i_raw, 1'b1};
   always_comb begin
      w_fix = '0;
      for (int i = 0; i < THERM_W; i++)
         w_fix[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i+1] & w_ext[i+2]) | (w_ext[i] & w_ext[i+2]);
   end
`else
   assign w_fix = i_raw;
`endif
   always_comb begin
      o_code = '0;
      for (int i = 0; i < THERM_W; i++)
         if (w_fix[i]) o_code = CODE_W'(i);
   end
   // a legal code has no set bit above a clear bit, so x & (x+1) is zero
   assign o_bubble = |(i_raw & (i_raw + THERM_W'(1)));
endmodule

// File: rtl/flash_adc_seq_ctrl.sv
// flash_adc_seq_ctrl: settle/sample/average sequencer for a flash ADC with valid/ready output.
// Optional FLASH_ADC_BUBBLE_FIX_EN enables majority bubble correction in the encoder.
module flash_adc_seq_ctrl
   import flash_adc_seq_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int AVG_LOG2      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               continuous,
   input  logic [THERM_W-1:0] therm_in,
   output logic               sample_en,
   output logic [CODE_W-1:0]  code_out,
   output logic               code_valid,
   input  logic               code_ready,
   output logic               busy,
   output logic               bubble_err
);
   localparam int N     = 1 << AVG_LOG2;
   localparam int ACC_W = CODE_W + AVG_LOG2;
   state_t              r_state, w_next;
   logic                r_start;
   logic [7:0]          r_settle_cnt;
   logic [4:0]          r_smp_cnt;
   logic [THERM_W-1:0]  r_smp;
   logic                r_smp_v;
   logic [ACC_W-1:0]    r_acc, w_sum;
   logic [CODE_W-1:0]   r_code, w_enc;
   logic                r_valid, r_bubble, w_bub, w_hs, w_enter;
   adc_therm_encoder u_enc (.i_raw(r_smp), .o_code(w_enc), .o_bubble(w_bub));
   assign w_hs    = r_valid & code_ready;
   assign w_sum   = r_acc + ACC_W'(w_enc);
   assign w_enter = (w_next == ST_SETTLE) && (r_state != ST_SETTLE);
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   w_next = r_start ? ST_SETTLE : ST_IDLE;
         ST_SETTLE: w_next = (r_settle_cnt == 8'(SETTLE_CYCLES - 1)) ? ST_SAMPLE : ST_SETTLE;
         ST_SAMPLE: w_next = (r_smp_cnt == 5'(N - 1)) ? ST_ACC : ST_SAMPLE;
         ST_ACC:    w_next = ST_HOLD;
         ST_HOLD:   w_next = w_hs ? (continuous ? ST_SETTLE : ST_IDLE) : ST_HOLD;
         default:   w_next = ST_IDLE;
      endcase
   end
   // start is captured only in IDLE, so requests while busy or at handshake are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_start      <= 1'b0;
         r_settle_cnt <= '0;
         r_smp_cnt    <= '0;
         r_smp        <= '0;
         r_smp_v      <= 1'b0;
         r_acc        <= '0;
         r_code       <= '0;
         r_valid      <= 1'b0;
         r_bubble     <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_start      <= start & (r_state == ST_IDLE) & ~r_start;
         r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + 8'd1 : '0;
         r_smp_cnt    <= (r_state == ST_SAMPLE) ? r_smp_cnt + 5'd1 : '0;
         r_smp_v      <= (r_state == ST_SAMPLE);
         if (r_state == ST_SAMPLE) r_smp <= therm_in;
         if (w_enter) r_acc <= '0;
         else if (r_smp_v) r_acc <= w_sum;
         if (w_enter) r_bubble <= 1'b0;
         else if (r_smp_v & w_bub) r_bubble <= 1'b1;
         // the final sample is folded in here, on the same edge it reaches the accumulator
         if (r_state == ST_ACC) begin
            r_code  <= CODE_W'(w_sum >> AVG_LOG2);
            r_valid <= 1'b1;
         end else if (w_hs) r_valid <= 1'b0;
      end
   end
   assign sample_en  = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
   assign busy       = (r_state != ST_IDLE);
   assign code_out   = r_code;
   assign code_valid = r_valid;
   assign bubble_err = r_bubble;
endmodule

// File: tb/tb_flash_adc_seq_ctrl.sv
// tb_flash_adc_seq_ctrl: directed checks of latency, averaging, bubbles, handshake, reset and continuous mode.
module tb_flash_adc_seq_ctrl;
   localparam int S = 4;
   localparam int N = 4;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, continuous = 1'b0, code_ready = 1'b0;
   logic [7:0] therm_in = 8'h00;
   logic       sample_en, code_valid, busy, bubble_err;
   logic [2:0] code_out;
   int         n_tests = 0, n_fail = 0, lat;
   flash_adc_seq_ctrl #(.SETTLE_CYCLES(S), .AVG_LOG2(2)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .therm_in(therm_in),
      .sample_en(sample_en), .code_out(code_out), .code_valid(code_valid),
      .code_ready(code_ready), .busy(busy), .bubble_err(bubble_err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // start pulse captured at edge k; samples j=0..N-1 alternate a/b; lat = edges after k until code_valid
   task automatic conv(input logic [7:0] a, input logic [7:0] b, input int spur, output int l);
      @(negedge clk);
      start = 1'b1;
      therm_in = a;
      @(posedge clk);
      #1 start = 1'b0;
      l = 99;
      for (int e = 1; e <= 40; e++) begin
         therm_in = (((e - (S + 2)) % 2) == 0) ? a : b;
         start = (e == spur);
         @(posedge clk);
         #1;
         if (code_valid) begin
            l = e;
            break;
         end
      end
      start = 1'b0;
   endtask
   task automatic hs;
      code_ready = 1'b1;
      @(posedge clk);
      #1 code_ready = 1'b0;
   endtask
   task automatic chk_zero(input string tag);
      check({tag, "_sample_en"}, sample_en, 0);
      check({tag, "_code_out"}, code_out, 0);
      check({tag, "_code_valid"}, code_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_bubble_err"}, bubble_err, 0);
   endtask
   initial begin
      #3 chk_zero("reset");
      @(negedge clk) rst = 1'b0;
      conv(8'h0F, 8'h0F, 0, lat);
      check("lat_0f", lat, S + N + 2);
      check("code_0f", code_out, 3);
      check("bub_0f", bubble_err, 0);
      check("busy_hold", busy, 1);
      check("smpen_hold", sample_en, 0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("hold_valid", code_valid, 1);
         check("hold_code", code_out, 3);
      end
      hs();
      check("hs_valid", code_valid, 0);
      check("hs_busy", busy, 0);
      conv(8'h07, 8'h1F, 0, lat);
      check("code_alt", code_out, 3);
      check("bub_alt", bubble_err, 0);
      hs();
      conv(8'h00, 8'h00, 0, lat);
      check("code_00", code_out, 0);
      hs();
      conv(8'hFF, 8'hFF, 0, lat);
      check("code_ff", code_out, 7);
      check("bub_ff", bubble_err, 0);
      hs();
      conv(8'h2F, 8'h2F, 0, lat);
`ifdef FLASH_ADC_BUBBLE_FIX_EN
      check("code_2f", code_out, 4);
`else
      check("code_2f", code_out, 5);
`endif
      check("bub_2f", bubble_err, 1);
      hs();
      conv(8'h0F, 8'h0F, 0, lat);
      check("bub_cleared", bubble_err, 0);
      hs();
      // continuous: restart only after the handshake, then finish and idle once continuous drops
      continuous = 1'b1;
      conv(8'h0F, 8'h0F, 0, lat);
      check("lat_cont", lat, S + N + 2);
      repeat (2) @(posedge clk);
      #1 check("cont_wait_smpen", sample_en, 0);
      check("cont_wait_valid", code_valid, 1);
      hs();
      check("cont_settle", sample_en, 1);
      check("cont_valid_drop", code_valid, 0);
      continuous = 1'b0;
      therm_in = 8'hFF;
      lat = 99;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (code_valid) begin
            lat = e;
            break;
         end
      end
      check("lat_restart", lat, S + N + 1);
      check("code_restart", code_out, 7);
      hs();
      check("cont_idle", busy, 0);
      // asynchronous reset in the second SAMPLE cycle
      @(negedge clk);
      start = 1'b1;
      therm_in = 8'hFF;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (S + 2) @(posedge clk);
      #1 check("pre_rst_smpen", sample_en, 1);
      rst = 1'b1;
      #1 chk_zero("midrst");
      @(negedge clk) rst = 1'b0;
      conv(8'h0F, 8'h0F, 0, lat);
      check("lat_after_rst", lat, S + N + 2);
      check("code_after_rst", code_out, 3);
      hs();
      // start pulsed during SETTLE is ignored
      conv(8'h07, 8'h07, 2, lat);
      check("lat_spur", lat, S + N + 2);
      check("code_spur", code_out, 2);
      hs();
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1 if (code_valid || busy) lat++;
      end
      check("spur_no_second", lat, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
